// File: rtl/serial_scan_pkg.sv
// Shared types and default constants for the serial scan controller.
//
// Contents:
//   scan_state_t  controller FSM states (IDLE, SHIFT, REPORT)
//   DEF_WIDTH     default bits per scanned word
//   DEF_PAT_LEN   default pattern length
//   DEF_PATTERN   default pattern, oldest bit in the MSB
//   idx_width()   width of a bit-index counter for a word of w bits
package serial_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } scan_state_t;

    localparam int          DEF_WIDTH   = 8;
    localparam int          DEF_PAT_LEN = 3;
    localparam logic [2:0]  DEF_PATTERN = 3'b101;

    // A one-bit word still needs a one-bit index register.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_scan_pattern_window.sv
// Serial pattern detector window.
//
// Keeps the last PAT_LEN pushed bits (newest in the LSB) and a saturating
// fill counter so that a window still holding reset zeros can never match.
//
// Ports:
//   Clk     in   rising-edge clock
//   Rst     in   asynchronous active-low reset (window and fill cleared)
//   clr     in   synchronous clear of window and fill
//   push    in   shift bit_in into the window this cycle
//   bit_in  in   bit being pushed
//   match   out  combinational: this push completes the pattern
module pattern_window
    import serial_scan_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    input  logic push,
    input  logic bit_in,
    output logic match
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] window_q;
    logic [FILL_W-1:0]  fill_q;

    logic [PAT_LEN:0]   shifted;
    logic [PAT_LEN-1:0] window_nx;
    logic [FILL_W-1:0]  fill_nx;

    // The match is judged on the window as it will be after this push, so a
    // hit is attributed to the bit that completes the pattern.
    always_comb begin
        shifted   = {window_q, bit_in};
        window_nx = shifted[PAT_LEN-1:0];
        fill_nx   = (fill_q == FILL_W'(PAT_LEN)) ? fill_q : fill_q + 1'b1;
        match     = push && (window_nx == PATTERN) && (fill_nx == FILL_W'(PAT_LEN));
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            window_q <= '0;
            fill_q   <= '0;
        end else if (clr) begin
            window_q <= '0;
            fill_q   <= '0;
        end else if (push) begin
            window_q <= window_nx;
            fill_q   <= fill_nx;
        end
    end

endmodule

// File: rtl/serial_scan_ctrl.sv
// Serial scan controller.
//
// Accepts a parallel word, pushes it MSB first through a pattern window one
// bit per clock, and presents the per-word hit count and per-bit hit mask on
// a valid/ready result port.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in REPORT, and the
// result holds steady until out_ready is seen. Both are decoded from the
// registered state alone.
//
// Ports:
//   Clk        in   rising-edge clock
//   Rst        in   asynchronous active-low reset
//   in_valid   in   input word valid
//   in_ready   out  controller can accept a word (IDLE)
//   in_data    in   word to scan, in_data[WIDTH-1] first
//   hist_clr   in   sampled with the word: clear window history before scan
//   out_valid  out  result valid (REPORT)
//   out_ready  in   consumer accepts result
//   hit_count  out  number of matches in the word
//   hit_mask   out  bit k set if a match completed on push of in_data[k]
//   busy       out  1 in SHIFT or REPORT
module serial_scan_ctrl
    import serial_scan_pkg::*;
#(
    parameter int                 WIDTH   = DEF_WIDTH,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    localparam int                CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             hist_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic [WIDTH-1:0] hit_mask,
    output logic             busy
);

    localparam int IDX_W = idx_width(WIDTH);

    scan_state_t      state_q;
    scan_state_t      state_d;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] word_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] mask_q;

    logic accept;
    logic push;
    logic cur_bit;
    logic match;

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                push = 1'b1;
                if (idx_q == '0) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cur_bit = word_q[idx_q];

    pattern_window #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_window (
        .Clk    (Clk),
        .Rst    (Rst),
        .clr    (accept && hist_clr),
        .push   (push),
        .bit_in (cur_bit),
        .match  (match)
    );

    // Word, index and result registers. The result is cleared at accept and
    // left untouched in REPORT, which keeps it stable while out_ready is low.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            word_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            mask_q <= '0;
        end else if (accept) begin
            word_q <= in_data;
            idx_q  <= IDX_W'(WIDTH - 1);
            cnt_q  <= '0;
            mask_q <= '0;
        end else if (push) begin
            if (match) begin
                mask_q[idx_q] <= 1'b1;
                cnt_q         <= cnt_q + 1'b1;
            end
            if (idx_q != '0) begin
                idx_q <= idx_q - 1'b1;
            end
        end
    end

    assign hit_count = cnt_q;
    assign hit_mask  = mask_q;

endmodule

// File: tb/tb_serial_scan_ctrl.sv
// Self-checking bench for serial_scan_ctrl (WIDTH=8, PAT_LEN=3, PATTERN=101).
// Directed steps with known answers, a randomized phase checked against a
// bit-history reference model, and a back-to-back streaming phase.
module tb_serial_scan_ctrl;

    localparam int                 WIDTH   = 8;
    localparam int                 PAT_LEN = 3;
    localparam logic [PAT_LEN-1:0] PATTERN = 3'b101;
    localparam int                 CNT_W   = $clog2(WIDTH + 1);
    localparam int                 PERIOD  = WIDTH + 2;
    localparam int                 RW      = CNT_W + WIDTH;

    logic             Clk;
    logic             Rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             hist_clr;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] hit_count;
    logic [WIDTH-1:0] hit_mask;
    logic             busy;

    int checks = 0;
    int errors = 0;

    bit          hist_q[$];
    logic [RW-1:0] exp_q[$];

    serial_scan_ctrl #(
        .WIDTH   (WIDTH),
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .hist_clr  (hist_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hit_count (hit_count),
        .hit_mask  (hit_mask),
        .busy      (busy)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    // Keeps the last PAT_LEN bits seen since the latest clear/reset and
    // compares them against the pattern after every bit of the word.
    function automatic logic [RW-1:0] model_word(input logic [WIDTH-1:0] data, input logic clr);
        int               cnt;
        logic [WIDTH-1:0] mask;
        logic [PAT_LEN-1:0] pat;
        bit               ok;
        cnt  = 0;
        mask = '0;
        pat  = PATTERN;
        if (clr) hist_q.delete();
        for (int k = WIDTH - 1; k >= 0; k--) begin
            hist_q.push_back(data[k]);
            if (hist_q.size() > PAT_LEN) void'(hist_q.pop_front());
            if (hist_q.size() == PAT_LEN) begin
                ok = 1'b1;
                for (int i = 0; i < PAT_LEN; i++) begin
                    if (hist_q[i] != pat[PAT_LEN-1-i]) ok = 1'b0;
                end
                if (ok) begin
                    cnt++;
                    mask[k] = 1'b1;
                end
            end
        end
        return {CNT_W'(cnt), mask};
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Called a little after a rising edge; returns 1 ns after the accept edge.
    task automatic send_word(input logic [WIDTH-1:0] data, input logic clr);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge Clk); #1;
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_data  = data;
        hist_clr = clr;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        hist_clr = 1'($urandom_range(0, 1));
    endtask

    // Waits for the result, checks latency/values, optionally stalls, consumes.
    task automatic collect(input logic [CNT_W-1:0] ecnt, input logic [WIDTH-1:0] emask, input int hold);
        int lat;
        lat = 0;
        check("busy_after_accept", busy, 1);
        while (!out_valid && lat < 100) begin
            @(posedge Clk); #1;
            lat++;
        end
        check("result_latency", lat, WIDTH);
        check("hit_count", hit_count, ecnt);
        check("hit_mask", hit_mask, emask);
        check("in_ready_in_report", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = WIDTH'($urandom);
            @(posedge Clk); #1;
            check("stall_out_valid", out_valid, 1);
            check("stall_hit_count", hit_count, ecnt);
            check("stall_hit_mask", hit_mask, emask);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge Clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_consume", out_valid, 0);
        check("in_ready_after_consume", in_ready, 1);
        check("busy_after_consume", busy, 0);
    endtask

    task automatic run_directed(input logic [WIDTH-1:0] data, input logic clr,
                                input logic [CNT_W-1:0] ecnt, input logic [WIDTH-1:0] emask,
                                input int hold);
        void'(model_word(data, clr));
        send_word(data, clr);
        collect(ecnt, emask, hold);
    endtask

    task automatic run_random(input logic [WIDTH-1:0] data, input logic clr, input int hold);
        logic [RW-1:0] e;
        e = model_word(data, clr);
        send_word(data, clr);
        collect(e[RW-1:WIDTH], e[WIDTH-1:0], hold);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_hit_count"}, hit_count, 0);
        check({tag, "_hit_mask"}, hit_mask, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int            accepts;
        int            results;
        int            last_acc;
        int            cyc;
        bit            seen_valid;
        bit            take;
        logic [RW-1:0] e;

        Rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        hist_clr  = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge Clk);
        #1;
        check_idle_outputs("reset");
        Rst = 1'b1;
        @(posedge Clk); #1;

        // 1. 8'hAA with history cleared.
        run_directed(8'hAA, 1'b1, 3, 8'h2A, 0);
        // 2. Overlapping matches.
        run_directed(8'hB5, 1'b1, 3, 8'h25, 0);
        // 3. Match spanning a word boundary, then the same word with history cleared.
        run_directed(8'h02, 1'b1, 0, 8'h00, 0);
        run_directed(8'h80, 1'b0, 1, 8'h80, 0);
        run_directed(8'h80, 1'b1, 0, 8'h00, 0);
        // 4. Consumer stall with stray in_valid pulses.
        run_directed(8'hAA, 1'b1, 3, 8'h2A, 5);

        // 5. Reset mid-scan discards the partial result.
        void'(model_word(8'hAA, 1'b1));
        send_word(8'hAA, 1'b1);
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        hist_q.delete();
        @(posedge Clk); #1;
        Rst = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 2 * PERIOD; c++) begin
            @(posedge Clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("no_result_after_reset", seen_valid, 0);
        run_directed(8'hAA, 1'b0, 3, 8'h2A, 0);

        // Randomized words against the reference model.
        for (int w = 0; w < 20; w++) begin
            run_random(WIDTH'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        // 6. Back-to-back streaming with out_ready tied high.
        out_ready = 1'b1;
        accepts   = 0;
        results   = 0;
        last_acc  = -1;
        cyc       = 0;
        in_valid  = 1'b1;
        in_data   = WIDTH'($urandom);
        hist_clr  = 1'($urandom_range(0, 1));
        while (results < 12 && cyc < 400) begin
            take = 1'b0;
            if (in_valid && in_ready) begin
                exp_q.push_back(model_word(in_data, hist_clr));
                if (last_acc >= 0) check("stream_accept_spacing", cyc - last_acc, PERIOD);
                last_acc = cyc;
                accepts++;
                take = 1'b1;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_hit_count", hit_count, e[RW-1:WIDTH]);
                    check("stream_hit_mask", hit_mask, e[WIDTH-1:0]);
                end
                results++;
            end
            @(posedge Clk); #1;
            cyc++;
            if (take) begin
                in_data  = WIDTH'($urandom);
                hist_clr = 1'($urandom_range(0, 1));
                if (accepts == 12) in_valid = 1'b0;
            end
        end
        check("stream_accepts", accepts, 12);
        check("stream_results", results, 12);
        check("stream_queue_empty", exp_q.size(), 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge Clk); #1;
        check("final_in_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
